// File: rtl/wb_regfile.sv
// Write-back stage and register file: one-entry write-back register feeding a
// 2**ADDR_W x DATA_W file, with two combinational read ports that bypass the pending entry.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] Bus_D,
    input  logic [ADDR_W-1:0] DA,
    input  logic              RW,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    output logic [DATA_W-1:0] A_data,
    output logic [DATA_W-1:0] B_data,
    output logic              wb_pend
);

    localparam int NREG = 2 ** ADDR_W;

    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_da;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] r_regs [NREG];
    logic              w_commit;

    assign w_commit = r_wb_valid && (r_wb_da != '0);
    assign wb_pend  = w_commit;

    // Flush has priority over stall; a stalled entry is simply held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_valid <= 1'b0;
            r_wb_da    <= '0;
            r_wb_data  <= '0;
        end else if (flush) begin
            r_wb_valid <= 1'b0;
        end else if (!stall) begin
            r_wb_valid <= RW;
            r_wb_da    <= DA;
            r_wb_data  <= Bus_D;
        end
    end

    // The entry held before the edge commits regardless of this edge's stall/flush.
    // R0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_wb_da] <= r_wb_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (r_wb_valid && (r_wb_da == addr)) begin
            val = r_wb_data;
        end else begin
            val = r_regs[addr];
        end
        return val;
    endfunction

    assign A_data = read_port(AA);
    assign B_data = read_port(BA);

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver pushes expected read results from a
// reference model into a queue; a monitor pops and compares them against the DUT.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Bus_D;
    logic [4:0]  DA;
    logic        RW;
    logic        stall;
    logic        flush;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic [31:0] A_data;
    logic [31:0] B_data;
    logic        wb_pend;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Bus_D  (Bus_D),
        .DA     (DA),
        .RW     (RW),
        .stall  (stall),
        .flush  (flush),
        .AA     (AA),
        .BA     (BA),
        .A_data (A_data),
        .B_data (B_data),
        .wb_pend(wb_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        pend;
    } exp_t;

    exp_t queue_exp[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    // Reference model: the architectural file plus at most one not-yet-committed write.
    bit [31:0] m_file [32];
    bit        m_pend_valid;
    bit [4:0]  m_pend_addr;
    bit [31:0] m_pend_data;

    function automatic bit [31:0] model_read(input bit [4:0] addr);
        if (addr == 0) return 32'h0;
        if (m_pend_valid && m_pend_addr == addr) return m_pend_data;
        return m_file[addr];
    endfunction

    task automatic model_clear();
        foreach (m_file[i]) m_file[i] = 32'h0;
        m_pend_valid = 0;
        m_pend_addr  = 0;
        m_pend_data  = 0;
    endtask

    // One clock edge: the old pending write lands, then the new one is taken (or not).
    task automatic model_edge();
        if (!reset_n) return;
        if (m_pend_valid && m_pend_addr != 0) m_file[m_pend_addr] = m_pend_data;
        if (flush) m_pend_valid = 0;
        else if (!stall) begin
            m_pend_valid = RW;
            m_pend_addr  = DA;
            m_pend_data  = Bus_D;
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        #1;
        e.tag  = tag;
        e.a    = model_read(AA);
        e.b    = model_read(BA);
        e.pend = m_pend_valid && (m_pend_addr != 0);
        queue_exp.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic step(input string tag, input bit rw, input bit [4:0] da, input bit [31:0] d,
                        input bit st, input bit fl, input bit [4:0] aa, input bit [4:0] ba);
        @(posedge clk);
        model_edge();
        #1;
        RW = rw; DA = da; Bus_D = d; stall = st; flush = fl; AA = aa; BA = ba;
        check_now(tag);
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        model_clear();
        check_now(tag);
        reset_n = 1'b1;
    endtask

    // Monitor: compares whatever the driver has queued each time outputs are sampled.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (queue_exp.size() > 0) begin
                e = queue_exp.pop_front();
                checks++;
                if (A_data !== e.a) begin
                    errors++;
                    $display("FAIL %s A_data got %h exp %h", e.tag, A_data, e.a);
                end
                checks++;
                if (B_data !== e.b) begin
                    errors++;
                    $display("FAIL %s B_data got %h exp %h", e.tag, B_data, e.b);
                end
                checks++;
                if (wb_pend !== e.pend) begin
                    errors++;
                    $display("FAIL %s wb_pend got %0b exp %0b", e.tag, wb_pend, e.pend);
                end
                $display("chk %-10s AA=%0d A=%h BA=%0d B=%h pend=%0b", e.tag, AA, A_data, BA, B_data, wb_pend);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        RW = 0; DA = 0; Bus_D = 0; stall = 0; flush = 0; AA = 7; BA = 7;
        model_clear();
        // Reset with no clock edge yet (first posedge at t=5).
        check_now("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Write then read via bypass, then via the file.
        step("wr_setup", 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        step("wr_bypass", 0, 0, 32'h0, 0, 0, 5, 0);
        step("wr_file", 0, 0, 32'h0, 0, 0, 0, 5);

        // R0 writes are captured but invisible.
        step("r0_setup", 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        step("r0_cap", 0, 0, 32'h0, 0, 0, 0, 0);
        step("r0_after", 0, 0, 32'h0, 0, 0, 0, 0);

        // Stall holds the entry; flush drops it without cancelling its commit.
        step("sf_cap", 1, 3, 32'h1234, 0, 0, 3, 4);
        step("sf_stall", 1, 4, 32'h9, 1, 0, 3, 4);
        step("sf_flushin", 1, 4, 32'h9, 0, 1, 3, 4);
        step("sf_flushed", 0, 0, 32'h0, 0, 0, 3, 4);
        step("sf_after", 0, 0, 32'h0, 0, 0, 3, 4);

        // Back-to-back writes to one register.
        step("b2b_1", 1, 9, 32'h1, 0, 0, 9, 9);
        step("b2b_2", 1, 9, 32'h2, 0, 0, 9, 9);
        step("b2b_3", 1, 9, 32'h3, 0, 0, 9, 9);
        step("b2b_rd3", 0, 0, 32'h0, 0, 0, 9, 9);
        step("b2b_file", 0, 0, 32'h0, 0, 0, 9, 9);

        // Asynchronous reset while a write is pending.
        step("ar_setup", 1, 6, 32'hAA, 0, 0, 6, 6);
        step("ar_pend", 0, 0, 32'h0, 0, 0, 6, 6);
        async_reset("ar_reset");
        step("ar_after", 0, 0, 32'h0, 0, 0, 6, 6);

        // Randomised traffic, biased toward a few addresses to provoke bypass hits.
        for (int n = 0; n < 400; n++) begin
            bit [4:0] da, aa, ba;
            da = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            aa = ($urandom_range(0, 1) == 0) ? da : 5'($urandom_range(0, 4));
            ba = 5'($urandom_range(0, 31));
            step("rand", 1'($urandom_range(0, 1)), da, $urandom(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), aa, ba);
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        #2;
        checks++;
        if (queue_exp.size() != 0) begin
            errors++;
            $display("FAIL drain queue size got %0d exp 0", queue_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
